raise_freq: RTL and testbench

- Frequency-domain pitch raiser in the voice-transformer pipeline, sitting between the FFT stage and the IFFT stage.
- Accepts two streamed 64-bin FFT frames (fft1 is the voice, fft2 is the mix/background).
- Shifts the fft1 spectrum up by SHIFT bins and adds fft2 bin-for-bin.
- Streams the resulting 64-bin frame out, one bin per cycle, with bin index and end-of-frame flag.

---
 rtl/raise_freq.sv | 184 ++++++++++++++++++
 tb/tb_raise_freq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raise_freq.sv
// raise_freq: frequency-domain pitch raiser between the FFT and IFFT stages.
// Two streamed 64-bin FFT frames are captured into ping-pong banks. The voice
// spectrum (fft1) is moved up by SHIFT bins, the mix spectrum (fft2) is added
// bin for bin with 16-bit saturation, and the result is streamed out one bin
// per cycle.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   clk_cal             reserved, unused
//   fft1_data/valid/fin, freq1  voice stream: {re16, im16}, qualifier, last bin, bin index
//   fft2_data/valid/fin, freq2  mix stream, same format
//   raise_valid         raise_data/freq_out valid
//   raise_fin           high with output bin 63
//   raise_data          output bin {re16, im16}
//   freq_out            output bin index
module raise_freq #(
    parameter int unsigned SHIFT = 4,
    parameter int unsigned NBINS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_cal,
    input  logic [31:0] fft1_data,
    input  logic        fft1_valid,
    input  logic [5:0]  freq1,
    input  logic        fft1_fin,
    input  logic [31:0] fft2_data,
    input  logic        fft2_valid,
    input  logic [5:0]  freq2,
    input  logic        fft2_fin,
    output logic        raise_valid,
    output logic        raise_fin,
    output logic [31:0] raise_data,
    output logic [5:0]  freq_out
);

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned HW    = 16;
    localparam int unsigned DEPTH = 2 * NBINS;

    localparam logic [AW-1:0] SHIFT_B  = AW'(SHIFT);
    localparam logic [AW-1:0] LAST_BIN = AW'(NBINS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bin memories: address = {bank, bin}
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    // Per-stream capture state
    logic          wb1, wb2;          // bank the next frame is written into
    logic          prev1, prev2;      // fin seen on the previous valid cycle
    logic [1:0]    done1, done2;      // bank holds a complete, unread frame

    // Output engine state
    state_t        state;
    logic [AW-1:0] k;
    logic          rd1, rd2;          // banks being read
    logic          rp1, rp2;          // bank to try first on the next start

    logic unused_clk_cal;
    assign unused_clk_cal = clk_cal;

    // Saturating 16-bit two's complement add
    function automatic logic [HW-1:0] sat_add(input logic [HW-1:0] x, input logic [HW-1:0] y);
        logic [HW:0] s;
        s = {x[HW-1], x} + {y[HW-1], y};
        if (s[HW] != s[HW-1]) begin
            return s[HW] ? 16'h8000 : 16'h7FFF;
        end
        return s[HW-1:0];
    endfunction

    logic last_c;
    assign last_c = (state == ST_RUN) && (k == LAST_BIN);

    // A frame landing on the bank under read mid-frame is steered to the other bank
    logic wbank1_c, wbank2_c;
    assign wbank1_c = ((state == ST_RUN) && !last_c && (wb1 == rd1)) ? ~wb1 : wb1;
    assign wbank2_c = ((state == ST_RUN) && !last_c && (wb2 == rd2)) ? ~wb2 : wb2;

    // Frame end only on the rising fin among valid cycles
    logic fe1_c, fe2_c;
    assign fe1_c = fft1_valid & fft1_fin & ~prev1;
    assign fe2_c = fft2_valid & fft2_fin & ~prev2;

    // Bank selection for the next output frame, oldest first
    logic sel1_c, sel2_c, avail1_c, avail2_c, start_c;
    assign sel1_c   = done1[rp1] ? rp1 : ~rp1;
    assign sel2_c   = done2[rp2] ? rp2 : ~rp2;
    assign avail1_c = done1[sel1_c] & ~((state == ST_RUN) & (sel1_c == rd1));
    assign avail2_c = done2[sel2_c] & ~((state == ST_RUN) & (sel2_c == rd2));
    assign start_c  = avail1_c & avail2_c & ((state == ST_IDLE) | last_c);

    // Completion flags: release on last read, drop when overwritten, set on frame end
    logic [1:0] done1_nxt_c, done2_nxt_c;
    always_comb begin
        done1_nxt_c = done1;
        done2_nxt_c = done2;
        if (last_c) begin
            done1_nxt_c[rd1] = 1'b0;
            done2_nxt_c[rd2] = 1'b0;
        end
        if (fft1_valid) done1_nxt_c[wbank1_c] = 1'b0;
        if (fft2_valid) done2_nxt_c[wbank2_c] = 1'b0;
        if (fe1_c)      done1_nxt_c[wbank1_c] = 1'b1;
        if (fe2_c)      done2_nxt_c[wbank2_c] = 1'b1;
    end

    // Bin memory writes (not reset)
    always_ff @(posedge clk) begin
        if (fft1_valid) mem1[{wbank1_c, freq1}] <= fft1_data;
        if (fft2_valid) mem2[{wbank2_c, freq2}] <= fft2_data;
    end

    // Capture bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb1   <= 1'b0;
            wb2   <= 1'b0;
            prev1 <= 1'b0;
            prev2 <= 1'b0;
            done1 <= 2'b00;
            done2 <= 2'b00;
        end else begin
            if (fft1_valid) prev1 <= fft1_fin;
            if (fft2_valid) prev2 <= fft2_fin;
            if (fe1_c)      wb1   <= ~wbank1_c;
            if (fe2_c)      wb2   <= ~wbank2_c;
            done1 <= done1_nxt_c;
            done2 <= done2_nxt_c;
        end
    end

    // Shifted voice bin: zero below SHIFT
    logic [AW:0]   src_c;
    logic [DW-1:0] a_c, b_c, sum_c;
    assign src_c = {1'b0, k} - {1'b0, SHIFT_B};
    assign a_c   = src_c[AW] ? '0 : mem1[{rd1, src_c[AW-1:0]}];
    assign b_c   = mem2[{rd2, k}];
    assign sum_c = {sat_add(a_c[31:16], b_c[31:16]), sat_add(a_c[15:0], b_c[15:0])};

    // Output engine: one bin per cycle, restarts on the last bin when a new pair is ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            rd1         <= 1'b0;
            rd2         <= 1'b0;
            rp1         <= 1'b0;
            rp2         <= 1'b0;
            raise_valid <= 1'b0;
            raise_fin   <= 1'b0;
            raise_data  <= '0;
            freq_out    <= '0;
        end else begin
            raise_valid <= 1'b0;
            raise_fin   <= 1'b0;
            raise_data  <= '0;
            freq_out    <= '0;
            if (state == ST_RUN) begin
                raise_valid <= 1'b1;
                raise_fin   <= last_c;
                raise_data  <= sum_c;
                freq_out    <= k;
                k           <= k + AW'(1);
                if (last_c && !start_c) state <= ST_IDLE;
            end
            if (start_c) begin
                state <= ST_RUN;
                k     <= '0;
                rd1   <= sel1_c;
                rd2   <= sel2_c;
                rp1   <= ~sel1_c;
                rp2   <= ~sel2_c;
            end
        end
    end

endmodule

// File: tb/tb_raise_freq.sv
// Bench for raise_freq: two instances (SHIFT=4 and SHIFT=0) share stimulus and
// are checked every cycle against a frame-level model of the output schedule.
module tb_raise_freq;

    logic        clk = 1'b0;
    logic        clk_cal = 1'b0;
    logic        rst;
    logic [31:0] fft1_data, fft2_data;
    logic        fft1_valid, fft2_valid, fft1_fin, fft2_fin;
    logic [5:0]  freq1, freq2;

    logic        v4, q4, v0, q0;
    logic [31:0] d4, d0;
    logic [5:0]  f4, f0;

    always #5 clk = ~clk;

    raise_freq #(.SHIFT(4), .NBINS(64)) dut4 (
        .clk(clk), .rst(rst), .clk_cal(clk_cal),
        .fft1_data(fft1_data), .fft1_valid(fft1_valid), .freq1(freq1), .fft1_fin(fft1_fin),
        .fft2_data(fft2_data), .fft2_valid(fft2_valid), .freq2(freq2), .fft2_fin(fft2_fin),
        .raise_valid(v4), .raise_fin(q4), .raise_data(d4), .freq_out(f4)
    );

    raise_freq #(.SHIFT(0), .NBINS(64)) dut0 (
        .clk(clk), .rst(rst), .clk_cal(clk_cal),
        .fft1_data(fft1_data), .fft1_valid(fft1_valid), .freq1(freq1), .fft1_fin(fft1_fin),
        .fft2_data(fft2_data), .fft2_valid(fft2_valid), .freq2(freq2), .fft2_fin(fft2_fin),
        .raise_valid(v0), .raise_fin(q0), .raise_data(d0), .freq_out(f0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] work1 [64];
    logic [31:0] work2 [64];
    logic [31:0] fq1[$], fq2[$];
    int          fe1[$], fe2[$];
    logic        prev1 = 1'b0, prev2 = 1'b0;
    int          sched_start[$];
    logic [31:0] sd4[$], sd0[$];
    int          last_start = -1000;

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b);
        logic signed [15:0] ar, ai, br, bi;
        ar = a[31:16]; ai = a[15:0]; br = b[31:16]; bi = b[15:0];
        return {sat16(int'(ar) + int'(br)), sat16(int'(ai) + int'(bi))};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            fq1.delete(); fq2.delete(); fe1.delete(); fe2.delete();
            sched_start.delete(); sd4.delete(); sd0.delete();
            prev1 = 1'b0; prev2 = 1'b0; last_start = -1000;
        end else begin
            if (fft1_valid) begin
                work1[freq1] = fft1_data;
                if (fft1_fin && !prev1) begin
                    for (int j = 0; j < 64; j++) fq1.push_back(work1[j]);
                    fe1.push_back(cyc);
                end
                prev1 = fft1_fin;
            end
            if (fft2_valid) begin
                work2[freq2] = fft2_data;
                if (fft2_fin && !prev2) begin
                    for (int j = 0; j < 64; j++) fq2.push_back(work2[j]);
                    fe2.push_back(cyc);
                end
                prev2 = fft2_fin;
            end
            if (fe1.size() > 0 && fe2.size() > 0) begin
                logic [31:0] a1 [64];
                logic [31:0] b2 [64];
                int e1, e2, st;
                e1 = fe1.pop_front();
                e2 = fe2.pop_front();
                st = ((e1 > e2) ? e1 : e2) + 2;
                if (st < last_start + 64) st = last_start + 64;
                last_start = st;
                sched_start.push_back(st);
                for (int j = 0; j < 64; j++) begin
                    a1[j] = fq1.pop_front();
                    b2[j] = fq2.pop_front();
                end
                for (int j = 0; j < 64; j++) begin
                    sd4.push_back(mix((j >= 4) ? a1[j-4] : 32'h0, b2[j]));
                    sd0.push_back(mix(a1[j], b2[j]));
                end
            end
        end
    end

    // ---------------- compare + capture ----------------
    logic [31:0] cap4 [64];
    logic [31:0] cap0 [64];
    int          fin4_cnt = 0;
    int          rise4 = 0;
    logic        v4_prev = 1'b0;
    int          first_valid = -1;

    task automatic check_out(input string name, input logic v, input logic q,
                             input logic [5:0] f, input logic [31:0] d,
                             input logic ev, input logic eq, input logic [5:0] ef,
                             input logic [31:0] ed);
        n_cmp++;
        if ({v, q, f, d} !== {ev, eq, ef, ed}) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got v=%0b fin=%0b freq=%0d data=%08h want v=%0b fin=%0b freq=%0d data=%08h",
                     name, cyc, v, q, f, d, ev, eq, ef, ed);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %08h want %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        ev, eq;
        logic [5:0]  ef;
        logic [31:0] e4, e0;
        int          kk;
        while (sched_start.size() > 0 && cyc > sched_start[0] + 63) begin
            void'(sched_start.pop_front());
            for (int j = 0; j < 64; j++) begin
                void'(sd4.pop_front());
                void'(sd0.pop_front());
            end
        end
        ev = 1'b0; eq = 1'b0; ef = '0; e4 = '0; e0 = '0;
        if (!rst && sched_start.size() > 0 && cyc >= sched_start[0]) begin
            kk = cyc - sched_start[0];
            ev = 1'b1;
            eq = (kk == 63);
            ef = 6'(kk);
            e4 = sd4[kk];
            e0 = sd0[kk];
        end
        check_out("out_shift4", v4, q4, f4, d4, ev, eq, ef, e4);
        check_out("out_shift0", v0, q0, f0, d0, ev, eq, ef, e0);
        if (v4) begin
            cap4[f4] = d4;
            if (first_valid < 0) first_valid = cyc;
        end
        if (v0) cap0[f0] = d0;
        if (q4) fin4_cnt++;
        if (v4 && !v4_prev) rise4++;
        v4_prev = v4;
    end

    // ---------------- stimulus ----------------
    int end2_edge = 0;

    task automatic clear_caps();
        for (int j = 0; j < 64; j++) begin
            cap4[j] = 32'hDEADBEEF;
            cap0[j] = 32'hDEADBEEF;
        end
        first_valid = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: ramp voice/zero mix, 1: saturating constants, 2: random
    task automatic drive(input int nframes, input int mode, input int skew2, input int hold);
        int total, c2, j;
        total = nframes * 64 + skew2;
        for (int c = 0; c < total; c++) begin
            fft1_valid = 1'b0; fft1_fin = 1'b0; freq1 = '0; fft1_data = $urandom();
            fft2_valid = 1'b0; fft2_fin = 1'b0; freq2 = '0; fft2_data = $urandom();
            if (c < nframes * 64) begin
                j = c % 64;
                fft1_valid = 1'b1;
                freq1 = 6'(j);
                fft1_fin = (j == 63);
                if (mode == 0)      fft1_data = {16'(j), 16'h0000};
                else if (mode == 1) fft1_data = 32'h7000_8100;
            end
            c2 = c - skew2;
            if (c2 >= 0 && c2 < nframes * 64) begin
                j = c2 % 64;
                fft2_valid = 1'b1;
                freq2 = 6'(j);
                fft2_fin = (j == 63);
                if (mode == 0)      fft2_data = 32'h0;
                else if (mode == 1) fft2_data = 32'h2000_8100;
                if (j == 63) end2_edge = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        for (int h = 0; h < hold; h++) begin
            fft1_valid = 1'b1; fft1_fin = 1'b1; freq1 = 6'd63; fft1_data = 32'h0;
            fft2_valid = 1'b1; fft2_fin = 1'b1; freq2 = 6'd63; fft2_data = 32'h0;
            @(posedge clk);
            #1;
        end
        fft1_valid = 1'b0; fft1_fin = 1'b0; freq1 = '0; fft1_data = '0;
        fft2_valid = 1'b0; fft2_fin = 1'b0; freq2 = '0; fft2_data = '0;
    endtask

    initial begin
        int fc, rc;
        bit hit;
        rst = 1'b1;
        fft1_valid = 1'b0; fft1_fin = 1'b0; freq1 = '0; fft1_data = '0;
        fft2_valid = 1'b0; fft2_fin = 1'b0; freq2 = '0; fft2_data = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ramp frame
        clear_caps();
        fc = fin4_cnt;
        drive(1, 0, 0, 0);
        idle(100);
        check_lit("ramp_bin2_zero", cap4[2], 32'h0000_0000);
        check_lit("ramp_bin10", cap4[10], 32'h0006_0000);
        check_lit("ramp_bin63", cap4[63], 32'h003B_0000);
        check_lit("ramp_shift0_bin5", cap0[5], 32'h0005_0000);
        check_lit("ramp_latency", 32'(first_valid), 32'(end2_edge + 2));
        check_lit("ramp_fin_count", 32'(fin4_cnt - fc), 32'd1);

        // Mix and saturation
        clear_caps();
        drive(1, 1, 0, 0);
        idle(100);
        check_lit("sat_shift0_bin0", cap0[0], 32'h7FFF_8000);
        check_lit("sat_shift0_bin63", cap0[63], 32'h7FFF_8000);
        check_lit("sat_shift4_bin1", cap4[1], 32'h2000_8100);
        check_lit("sat_shift4_bin30", cap4[30], 32'h7FFF_8000);

        // Continuous random frames followed by a held fin
        fc = fin4_cnt;
        rc = rise4;
        drive(8, 2, 0, 40);
        idle(100);
        check_lit("stream_fin_count", 32'(fin4_cnt - fc), 32'd8);
        check_lit("stream_valid_runs", 32'(rise4 - rc), 32'd1);

        // Skewed streams
        clear_caps();
        drive(1, 2, 10, 0);
        idle(100);
        check_lit("skew_latency", 32'(first_valid), 32'(end2_edge + 2));

        // Reset during output bin 20
        drive(1, 2, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (v4 && f4 == 6'd20) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reset_wait_bin20 got timeout want bin 20");
        end
        #1 rst = 1'b1;
        #1;
        check_lit("rst_valid4", {31'b0, v4}, 32'h0);
        check_lit("rst_data4", d4, 32'h0);
        check_lit("rst_freq4", {26'b0, f4}, 32'h0);
        check_lit("rst_data0", d0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_caps();
        drive(1, 0, 0, 0);
        idle(100);
        check_lit("post_rst_bin10", cap4[10], 32'h0006_0000);
        check_lit("post_rst_bin63", cap4[63], 32'h003B_0000);
        check_lit("post_rst_latency", 32'(first_valid), 32'(end2_edge + 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
